execute_stage: RTL and testbench
================================

# execute_stage

Pipeline execute stage sitting directly upstream of the memory-access stage. Each cycle it takes decoded operands and control from the decode/register-read stage, computes an ALU result, and registers the result, store data, destination register and the write-back and memory-access controls for the memory-access stage to consume. Multiply is executed iteratively over 32 cycles, and the stage stalls upstream for the duration.

## Interface
- `clk` input, 1: rising-edge clock.
- `resetN` input, 1: asynchronous, active-low reset.
- `validIn` input, 1: the upstream instruction is present this cycle.
- `aluOp` input, 3: operation code, 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MUL, 7 PASSB.
- `operandA` input, 32: first ALU operand.
- `operandB` input, 32: second ALU operand (register value or immediate, already selected upstream).
- `writeDataIn` input, 32: store data carried through to memory access.
- `rdIn` input, 5: destination register.
- `writeBackControlIn` input, 2: write-back control, carried through.
- `memAccessControlIn` input, 2: memory control, carried through (0 none, 1 read, 2 write).
- `stall` output, 1: combinational; upstream must hold all inputs while it is 1.
- `resultOut` output, 32: registered ALU result; this is the address or data input of the memory-access stage.
- `writeDataOut` output, 32: registered store data.
- `rdOut` output, 5: registered destination register.
- `writeBackControlOut` output, 2: registered write-back control.
- `memAccessControlOut` output, 2: registered memory control.

## Operation
- States: IDLE and MUL.
- IDLE, `validIn`=1, `aluOp`≠6: at the rising edge, all outputs load the computed result and the carried fields.
- IDLE, `validIn`=0: at the edge, the stage emits a bubble. A bubble sets all outputs to 0.
- IDLE, `validIn`=1, `aluOp`=6:
  - `stall`=1 immediately.
  - At the edge, the stage stashes the multiplicand (A), multiplier (B), `writeDataIn`, `rdIn` and both controls; clears the accumulator and `count`; goes to MUL; and emits a bubble.
- MUL: each edge processes one multiplier bit, LSB first:
  - if the bit is 1, add the shifted multiplicand to the accumulator;
  - shift the multiplicand left and the multiplier right.
  - While `count`<31, emit a bubble and increment `count`.
  - When `count`=31, `stall`=0. At that edge the stage loads the final product's low 32 bits together with the stashed fields into the outputs and returns to IDLE.
- Inputs are ignored in MUL; only the stashed copies are used.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^32; overflow is not flagged.
  - SLT yields 1 or 0 from a signed compare.
  - PASSB yields B.
- `stall` = (IDLE & `validIn` & `aluOp`=6) | (MUL & `count`<31).

## Timing
- Reset value: every output is 0, the state is IDLE and `count` is 0. `stall` is 0 unless the inputs request a MUL.
- Single-cycle ops: 1-cycle latency; the outputs are valid after the edge that samples the inputs.
- MUL:
  - The accept edge is E0. The result appears after E32.
  - `stall` is high from the first presentation of the instruction through the cycle before E32.
  - Upstream advances at E32, the same edge that the result is written.
  - Throughput is one MUL per 33 cycles.
- Back-to-back MUL: the second MUL is sampled in IDLE after E32, so it is accepted at E33.
- Reset asserted mid-MUL: outputs are cleared immediately (asynchronously), the stashed operation is dropped and the state returns to IDLE.
- `validIn` dropping while `stall`=1 is an upstream protocol violation and is ignored in MUL.

## Configuration
- Macro `EXEC_MUL_EN`.
- Defined: iterative multiplier, MUL state and stall behave as described.
- Undefined: no multiplier or MUL state is built and `stall` is tied to 0. `aluOp`=6 completes in one cycle with `resultOut`=0; the carried fields still pass through.

## Test plan
- Reset: drive `resetN`=0 asynchronously mid-cycle -> all outputs 0 with no clock edge, `stall`=0.
- ADD then SUB:
  - A=100, B=20, rd=5, `memAccessControlIn`=2, `writeDataIn`=20 -> next edge `resultOut`=120, `rdOut`=5, `memAccessControlOut`=2, `writeDataOut`=20.
  - SUB with A=3, B=5 -> `resultOut`=0xFFFFFFFE.
- SLT: A=0xFFFFFFFF, B=1 -> `resultOut`=1; swapped operands -> `resultOut`=0.
- MUL, rd=7, `writeBackControlIn`=1:
  - A=1234, B=5678 -> `stall` high for exactly 32 cycles;
  - bubbles output during the stall;
  - after E32, `resultOut`=7006652, `rdOut`=7, `writeBackControlOut`=1.
- MUL wrap: A=0x10000, B=0x10000 -> `resultOut`=0. A MUL immediately followed by ADD(1,1) -> ADD result 2 appears after E33.
- Reset at E10 of a MUL -> outputs 0, `stall`=0, state IDLE. A subsequent ADD(1,2) -> `resultOut`=3 one cycle later.

Source files
------------

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : ALU execute stage feeding memory access; optional 32-cycle
//            iterative multiplier built only when EXEC_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_validIn,
  input  logic [2:0]  i_aluOp,
  input  logic [31:0] i_operandA,
  input  logic [31:0] i_operandB,
  input  logic [31:0] i_writeDataIn,
  input  logic [4:0]  i_rdIn,
  input  logic [1:0]  i_writeBackControlIn,
  input  logic [1:0]  i_memAccessControlIn,
  output logic        o_stall,
  output logic [31:0] o_resultOut,
  output logic [31:0] o_writeDataOut,
  output logic [4:0]  o_rdOut,
  output logic [1:0]  o_writeBackControlOut,
  output logic [1:0]  o_memAccessControlOut
);

  localparam logic [2:0] c_OP_ADD   = 3'd0;
  localparam logic [2:0] c_OP_SUB   = 3'd1;
  localparam logic [2:0] c_OP_AND   = 3'd2;
  localparam logic [2:0] c_OP_OR    = 3'd3;
  localparam logic [2:0] c_OP_XOR   = 3'd4;
  localparam logic [2:0] c_OP_SLT   = 3'd5;
  localparam logic [2:0] c_OP_MUL   = 3'd6;
  localparam logic [2:0] c_OP_PASSB = 3'd7;

  logic [31:0] w_alu;

  // MUL falls into the default arm: its single-cycle value is 0
  always_comb begin
    w_alu = 32'd0;
    case (i_aluOp)
      c_OP_ADD:   w_alu = i_operandA + i_operandB;
      c_OP_SUB:   w_alu = i_operandA - i_operandB;
      c_OP_AND:   w_alu = i_operandA & i_operandB;
      c_OP_OR:    w_alu = i_operandA | i_operandB;
      c_OP_XOR:   w_alu = i_operandA ^ i_operandB;
      c_OP_SLT:   w_alu = {31'd0, ($signed(i_operandA) < $signed(i_operandB))};
      c_OP_PASSB: w_alu = i_operandB;
      default:    w_alu = 32'd0;
    endcase
  end

  logic        w_load;
  logic [31:0] w_res;
  logic [31:0] w_wd;
  logic [4:0]  w_rd;
  logic [1:0]  w_wb;
  logic [1:0]  w_mem;

`ifdef EXEC_MUL_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_count;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [31:0] r_wd;
  logic [4:0]  r_rd;
  logic [1:0]  r_wb;
  logic [1:0]  r_mem;
  logic        w_accept;
  logic        w_stall;
  logic [31:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_res        = w_alu;
    w_wd         = i_writeDataIn;
    w_rd         = i_rdIn;
    w_wb         = i_writeBackControlIn;
    w_mem        = i_memAccessControlIn;
    case (r_state)
      S_IDLE: begin
        if (i_validIn) begin
          if (i_aluOp == c_OP_MUL) begin
            w_stall      = 1'b1;
            w_accept     = 1'b1;
            w_next_state = S_MUL;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_res = w_acc_next;
        w_wd  = r_wd;
        w_rd  = r_rd;
        w_wb  = r_wb;
        w_mem = r_mem;
        if (r_count != 5'd31) begin
          w_stall = 1'b1;
        end else begin
          w_load       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Only the low 32 product bits are kept, so the multiplicand may shift out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 5'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_wd     <= 32'd0;
      r_rd     <= 5'd0;
      r_wb     <= 2'd0;
      r_mem    <= 2'd0;
    end else if (w_accept) begin
      r_count  <= 5'd0;
      r_mcand  <= i_operandA;
      r_mplier <= i_operandB;
      r_acc    <= 32'd0;
      r_wd     <= i_writeDataIn;
      r_rd     <= i_rdIn;
      r_wb     <= i_writeBackControlIn;
      r_mem    <= i_memAccessControlIn;
    end else if (r_state == S_MUL) begin
      r_count  <= r_count + 5'd1;
      r_mcand  <= {r_mcand[30:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_acc    <= w_acc_next;
    end
  end

  assign o_stall = w_stall;
`else
  assign w_load  = i_validIn;
  assign w_res   = w_alu;
  assign w_wd    = i_writeDataIn;
  assign w_rd    = i_rdIn;
  assign w_wb    = i_writeBackControlIn;
  assign w_mem   = i_memAccessControlIn;
  assign o_stall = 1'b0;
`endif

  // Anything not loaded this edge becomes a bubble (all zero)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_resultOut           <= 32'd0;
      o_writeDataOut        <= 32'd0;
      o_rdOut               <= 5'd0;
      o_writeBackControlOut <= 2'd0;
      o_memAccessControlOut <= 2'd0;
    end else if (w_load) begin
      o_resultOut           <= w_res;
      o_writeDataOut        <= w_wd;
      o_rdOut               <= w_rd;
      o_writeBackControlOut <= w_wb;
      o_memAccessControlOut <= w_mem;
    end else begin
      o_resultOut           <= 32'd0;
      o_writeDataOut        <= 32'd0;
      o_rdOut               <= 5'd0;
      o_writeBackControlOut <= 2'd0;
      o_memAccessControlOut <= 2'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Self-checking bench for execute_stage (with or without EXEC_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validIn;
  logic [2:0]  aluOp;
  logic [31:0] opA, opB, wdIn;
  logic [4:0]  rdIn;
  logic [1:0]  wbIn, memIn;
  logic        stall;
  logic [31:0] resOut, wdOut;
  logic [4:0]  rdOut;
  logic [1:0]  wbOut, memOut;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_validIn             (validIn),
    .i_aluOp               (aluOp),
    .i_operandA            (opA),
    .i_operandB            (opB),
    .i_writeDataIn         (wdIn),
    .i_rdIn                (rdIn),
    .i_writeBackControlIn  (wbIn),
    .i_memAccessControlIn  (memIn),
    .o_stall               (stall),
    .o_resultOut           (resOut),
    .o_writeDataOut        (wdOut),
    .o_rdOut               (rdOut),
    .o_writeBackControlOut (wbOut),
    .o_memAccessControlOut (memOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_res = 0, m_wd = 0;
  logic [4:0]  m_rd = 0;
  logic [1:0]  m_wb = 0, m_mem = 0;
  int          mul_left = 0;   // edges still to go before a pending product lands
  logic [31:0] s_prod, s_wd;
  logic [4:0]  s_rd;
  logic [1:0]  s_wb, s_mem;

  function automatic logic [31:0] f_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return 32'd0;
      default: return b;
    endcase
  endfunction

  task automatic m_set(input logic [31:0] r, input logic [31:0] w, input logic [4:0] d,
                       input logic [1:0] b, input logic [1:0] m);
    m_res = r; m_wd = w; m_rd = d; m_wb = b; m_mem = m;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_set(0, 0, 0, 0, 0);
      mul_left = 0;
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) m_set(s_prod, s_wd, s_rd, s_wb, s_mem);
      else               m_set(0, 0, 0, 0, 0);
    end else if (validIn) begin
`ifdef EXEC_MUL_EN
      if (aluOp == 3'd6) begin
        s_prod = opA * opB;
        s_wd = wdIn; s_rd = rdIn; s_wb = wbIn; s_mem = memIn;
        mul_left = 32;
        m_set(0, 0, 0, 0, 0);
      end else
`endif
        m_set(f_alu(aluOp, opA, opB), wdIn, rdIn, wbIn, memIn);
    end else begin
      m_set(0, 0, 0, 0, 0);
    end
  end

  function automatic logic f_exp_stall();
`ifdef EXEC_MUL_EN
    return (mul_left > 1) || (mul_left == 0 && validIn && aluOp == 3'd6);
`else
    return 1'b0;
`endif
  endfunction

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("cyc_result", resOut, m_res);
    chk("cyc_wdata", wdOut, m_wd);
    chk("cyc_rd", {27'd0, rdOut}, {27'd0, m_rd});
    chk("cyc_wb", {30'd0, wbOut}, {30'd0, m_wb});
    chk("cyc_mem", {30'd0, memOut}, {30'd0, m_mem});
    chk("cyc_stall", {31'd0, stall}, {31'd0, f_exp_stall()});
  end

  // ---------------- stimulus ----------------
  int stall_cycles;

  task automatic chk_zero(input string name);
    chk({name, "_res"}, resOut, 0);
    chk({name, "_wd"}, wdOut, 0);
    chk({name, "_rd"}, {27'd0, rdOut}, 0);
    chk({name, "_wb"}, {30'd0, wbOut}, 0);
    chk({name, "_mem"}, {30'd0, memOut}, 0);
    chk({name, "_stall"}, {31'd0, stall}, 0);
  endtask

  // Present an instruction and hold it while stall is high (bounded)
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [1:0] wb, input logic [1:0] mem);
    int n;
    @(negedge clk);
    validIn = 1'b1; aluOp = op; opA = a; opB = b; wdIn = wd; rdIn = rd; wbIn = wb; memIn = mem;
    n = 0;
    #1;
    while (stall && n < 100) begin
      if (n == 16) chk("mul_bubble", resOut, 0);
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("stall_timeout", n, 0);
    stall_cycles = n;
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] wd, input logic [4:0] rd,
                     input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] exp_res);
    issue(op, a, b, wd, rd, wb, mem);
    @(posedge clk);
    #2;
    chk({name, "_res"}, resOut, exp_res);
    chk({name, "_rd"}, {27'd0, rdOut}, {27'd0, rd});
    chk({name, "_wb"}, {30'd0, wbOut}, {30'd0, wb});
    chk({name, "_mem"}, {30'd0, memOut}, {30'd0, mem});
    chk({name, "_wd"}, wdOut, wd);
  endtask

  initial begin
    rst_n = 1'b0; validIn = 1'b0; aluOp = 0; opA = 0; opB = 0;
    wdIn = 0; rdIn = 0; wbIn = 0; memIn = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run("add", 3'd0, 32'd100, 32'd20, 32'd20, 5'd5, 2'd0, 2'd2, 32'd120);

    // Asynchronous reset mid-cycle, no clock edge in between
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;

    run("sub",   3'd1, 32'd3, 32'd5, 32'h0, 5'd1, 2'd1, 2'd0, 32'hFFFF_FFFE);
    run("slt1",  3'd5, 32'hFFFF_FFFF, 32'd1, 32'h11, 5'd2, 2'd1, 2'd0, 32'd1);
    run("slt0",  3'd5, 32'd1, 32'hFFFF_FFFF, 32'h22, 5'd3, 2'd1, 2'd0, 32'd0);
    run("and",   3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 5'd4, 2'd2, 2'd1, 32'h00F0_1200);
    run("or",    3'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 5'd6, 2'd3, 2'd0, 32'hFFF0_FF34);
    run("xor",   3'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 5'd8, 2'd1, 2'd0, 32'hFF00_ED34);
    run("passb", 3'd7, 32'hDEAD_BEEF, 32'h0FF0_FF00, 32'h0, 5'd9, 2'd1, 2'd0, 32'h0FF0_FF00);

    @(negedge clk) validIn = 1'b0;
    @(posedge clk) #2 chk_zero("bubble");

`ifdef EXEC_MUL_EN
    run("mul", 3'd6, 32'd1234, 32'd5678, 32'h0, 5'd7, 2'd1, 2'd0, 32'd7006652);
    chk("mul_stall_cycles", stall_cycles, 32);
`else
    run("mul", 3'd6, 32'd1234, 32'd5678, 32'h0, 5'd7, 2'd1, 2'd0, 32'd0);
    chk("mul_stall_cycles", stall_cycles, 0);
`endif

    run("mulwrap", 3'd6, 32'h0001_0000, 32'h0001_0000, 32'h5, 5'd10, 2'd1, 2'd0, 32'd0);
    run("add_b2b", 3'd0, 32'd1, 32'd1, 32'h0, 5'd11, 2'd1, 2'd0, 32'd2);

    // Reset asserted after the tenth edge of a multiply
    @(negedge clk);
    validIn = 1'b1; aluOp = 3'd6; opA = 32'd5; opB = 32'd7; wdIn = 0; rdIn = 5'd12; wbIn = 2'd1; memIn = 0;
    repeat (11) @(posedge clk);
    #2 validIn = 1'b0; rst_n = 1'b0;
    #1 chk_zero("mul_rst");
    @(negedge clk) rst_n = 1'b1;
    run("add_after_rst", 3'd0, 32'd1, 32'd2, 32'h0, 5'd13, 2'd1, 2'd0, 32'd3);

    @(negedge clk) validIn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
